// File: rtl/if_id_stage_if.sv
// Fetch-side handshake between the program-counter stage (master) and the
// IF/ID pipeline register (slave): address, instruction word, valid, ready.
`timescale 1ns/1ps
interface if_id_stage_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) ();
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic               if_valid;
  logic               if_ready;

  modport master (output if_pc, output if_instr, output if_valid, input if_ready);
  modport slave  (input if_pc, input if_instr, input if_valid, output if_ready);
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: one main slot presented to decode plus one skid slot
// that absorbs the instruction in flight when decode stalls. Flush drops both.
// Optional feature: define IF_ID_STATS_EN to add saturating stall/flush counters.
`timescale 1ns/1ps
module if_id_stage #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  if_id_stage_if.slave       fetch,
  input  logic               id_stall,
  input  logic               flush,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    id_pc_plus4,
  output logic [INSTR_W-1:0] id_instr,
  output logic               id_valid
`ifdef IF_ID_STATS_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic               ready_q;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;

  logic accept, advance;
  logic load_in, load_from_skid, load_skid, clr_main;

  assign accept         = fetch.if_valid & ready_q;
  assign advance        = id_valid & ~id_stall;
  assign id_valid       = (state != EMPTY);
  assign fetch.if_ready = ready_q;

  // State register; ready is registered from the next state so it never
  // depends combinationally on stall, flush or valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nx;
      ready_q <= (state_nx != SKID);
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) state_nx = FULL;
        FULL: begin
          if (advance && !accept)      state_nx = EMPTY;
          else if (!advance && accept) state_nx = SKID;
        end
        SKID:    if (advance) state_nx = FULL;
        default: state_nx = EMPTY;
      endcase
    end
  end

  // Slot load controls decoded from state and handshake.
  always_comb begin
    load_in        = 1'b0;
    load_from_skid = 1'b0;
    load_skid      = 1'b0;
    clr_main       = 1'b0;
    if (flush) begin
      clr_main = 1'b1;
    end else begin
      case (state)
        EMPTY: load_in = accept;
        FULL: begin
          load_in   = accept & advance;
          load_skid = accept & ~advance;
        end
        SKID:    load_from_skid = advance;
        default: ;
      endcase
    end
  end

  // Main slot: the decode-facing registers; pc_plus4 is computed at load time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc       <= '0;
      id_pc_plus4 <= PC_W'(4);
      id_instr    <= NOP_INSTR;
    end else if (clr_main) begin
      id_instr <= NOP_INSTR;
    end else if (load_in) begin
      id_pc       <= fetch.if_pc;
      id_pc_plus4 <= fetch.if_pc + PC_W'(4);
      id_instr    <= fetch.if_instr;
    end else if (load_from_skid) begin
      id_pc       <= skid_pc;
      id_pc_plus4 <= skid_pc + PC_W'(4);
      id_instr    <= skid_instr;
    end
  end

  // Skid slot: captures the in-flight instruction when decode stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (load_skid) begin
      skid_pc    <= fetch.if_pc;
      skid_instr <= fetch.if_instr;
    end
  end

`ifdef IF_ID_STATS_EN
  // Saturating event counters for stalled-decode and flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (id_valid && id_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != '1)                flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage against a queue-based reference model.
`timescale 1ns/1ps
module tb_if_id_stage;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] id_pc, id_pc_plus4, id_instr;
  logic        id_valid;
`ifdef IF_ID_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  if_id_stage_if #(.PC_W(32), .INSTR_W(32)) bus ();

  if_id_stage #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .fetch(bus.slave), .id_stall(id_stall), .flush(flush),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_instr(id_instr), .id_valid(id_valid)
`ifdef IF_ID_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of held instructions (capacity 2) plus the last
  // word presented to decode, which persists while nothing is held.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc, m_instr;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [97:0] obs, exp_v;

  function automatic logic [97:0] expected();
    return {q.size() > 0, q.size() < 2, m_pc, m_pc + 32'd4, m_instr};
  endfunction

  function automatic logic [97:0] observed();
    return {id_valid, bus.if_ready, id_pc, id_pc_plus4, id_instr};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, and return
  // at the following falling edge ready for sampling.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic st, input logic fl);
    logic acc;
    bus.if_valid = v; bus.if_pc = pc; bus.if_instr = ins;
    id_stall = st; flush = fl;
    acc = v && (q.size() < 2);
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_instr = NOP;
    end else begin
      if (q.size() > 0 && !st) void'(q.pop_front());
      if (acc) q.push_back('{pc: pc, instr: ins});
    end
    if (q.size() > 0) begin
      m_pc = q[0].pc;
      m_instr = q[0].instr;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    m_pc = 32'h0;
    m_instr = NOP;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_instr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    obs = observed(); n_cmp++;
    if (obs !== {1'b0, 1'b1, 32'h0, 32'h4, NOP}) begin
      n_bad++; $display("FAIL reset_values: got %h want %h", obs, {1'b0, 1'b1, 32'h0, 32'h4, NOP});
    end
    rst_n = 1'b1;
    drive(1'b1, 32'h100, 32'h8C01_0004, 1'b0, 1'b0);
    n_cmp++;
    if ({id_valid, id_pc, id_pc_plus4, id_instr} !== {1'b1, 32'h100, 32'h104, 32'h8C01_0004}) begin
      n_bad++; $display("FAIL first_load: got %h/%h/%h/%h want 1/100/104/8c010004",
                        id_valid, id_pc, id_pc_plus4, id_instr);
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
      n_cmp++;
      if ({id_valid, bus.if_ready, id_pc} !== {1'b1, 1'b1, 32'(i * 4)}) begin
        n_bad++; $display("FAIL stream[%0d]: got v=%b rdy=%b pc=%h want 1/1/%h",
                          i, id_valid, bus.if_ready, id_pc, 32'(i * 4));
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    obs = observed(); exp_v = expected(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL stream_drain: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_stall_skid();
    drive(1'b1, 32'h10, 32'h1111_0010, 1'b0, 1'b0);
    drive(1'b1, 32'h14, 32'h1111_0014, 1'b1, 1'b0);
    n_cmp++;
    if ({bus.if_ready, id_pc, id_valid} !== {1'b0, 32'h10, 1'b1}) begin
      n_bad++; $display("FAIL skid_hold: got rdy=%b pc=%h v=%b want 0/10/1", bus.if_ready, id_pc, id_valid);
    end
    drive(1'b1, 32'h18, 32'h1111_0018, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.if_ready, id_pc, id_instr} !== {1'b1, 32'h14, 32'h1111_0014}) begin
      n_bad++; $display("FAIL skid_release: got rdy=%b pc=%h ins=%h want 1/14/11110014", bus.if_ready, id_pc, id_instr);
    end
    drive(1'b1, 32'h18, 32'h1111_0018, 1'b0, 1'b0);
    n_cmp++;
    if ({id_valid, id_pc, id_pc_plus4} !== {1'b1, 32'h18, 32'h1C}) begin
      n_bad++; $display("FAIL skid_next: got v=%b pc=%h p4=%h want 1/18/1c", id_valid, id_pc, id_pc_plus4);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    obs = observed(); exp_v = expected(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL skid_model: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h30, 32'h2222_0030, 1'b0, 1'b0);
    drive(1'b1, 32'h34, 32'h2222_0034, 1'b1, 1'b0);
    drive(1'b1, 32'h40, 32'h2222_0040, 1'b1, 1'b1);
    n_cmp++;
    if ({id_valid, id_instr, bus.if_ready, id_pc} !== {1'b0, NOP, 1'b1, 32'h30}) begin
      n_bad++; $display("FAIL flush: got v=%b ins=%h rdy=%b pc=%h want 0/%h/1/30",
                        id_valid, id_instr, bus.if_ready, id_pc, NOP);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (id_valid !== 1'b0 || id_pc === 32'h40) begin
      n_bad++; $display("FAIL flush_after: got v=%b pc=%h want v=0 pc!=40", id_valid, id_pc);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 32'hFFFF_FFFC, 32'h3333_3333, 1'b0, 1'b0);
    n_cmp++;
    if ({id_pc, id_pc_plus4} !== {32'hFFFF_FFFC, 32'h0}) begin
      n_bad++; $display("FAIL wrap: got pc=%h p4=%h want fffffffc/00000000", id_pc, id_pc_plus4);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, $urandom & 32'hFFFF_FFFC, $urandom,
            ($urandom % 3) == 0, ($urandom % 16) == 0);
      obs = observed(); exp_v = expected(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL random[%0d]: got %h want %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 32'h50, 32'h4444_0050, 1'b0, 1'b0);
    drive(1'b1, 32'h54, 32'h4444_0054, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    obs = observed(); n_cmp++;
    if (obs !== {1'b0, 1'b1, 32'h0, 32'h4, NOP}) begin
      n_bad++; $display("FAIL reset_async: got %h want %h", obs, {1'b0, 1'b1, 32'h0, 32'h4, NOP});
    end
    bus.if_valid = 1'b0; id_stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h60, 32'h4444_0060, 1'b0, 1'b0);
    obs = observed(); exp_v = expected(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL reset_recover: got %h want %h", obs, exp_v); end
  endtask

`ifdef IF_ID_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    bus.if_valid = 1'b0; id_stall = 1'b0; flush = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== 32'h0) begin
      n_bad++; $display("FAIL stats_reset: got %h/%h want 0/0", stall_cnt, flush_cnt);
    end
    drive(1'b1, 32'h200, 32'h5555_0000, 1'b0, 1'b0);
    repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (2) drive(1'b0, '0, '0, 1'b0, 1'b1);
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== {16'd3, 16'd2}) begin
      n_bad++; $display("FAIL stats_count: got %0d/%0d want 3/2", stall_cnt, flush_cnt);
    end
    drive(1'b1, 32'h300, 32'h5555_0300, 1'b0, 1'b0);
    repeat (70000) drive(1'b0, '0, '0, 1'b1, 1'b0);
    n_cmp++;
    if ({stall_cnt, flush_cnt} !== {16'hFFFF, 16'd2}) begin
      n_bad++; $display("FAIL stats_saturate: got %h/%h want ffff/0002", stall_cnt, flush_cnt);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush();
    test_wrap();
    test_random();
    test_reset_midflight();
`ifdef IF_ID_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
